// File: rtl/ap_dma_scheduler_if.sv
// Bus bundle between ap_dma_scheduler and the instruction FIFO, DMA engine and accelerator queues.
// master = scheduler side, slave = surrounding FIFOs / DMA engine.
interface ap_dma_scheduler_if #(
    parameter int unsigned ISA    = 2,
    parameter int unsigned ADDR   = 32,
    parameter int unsigned BITLEN = 64
);
    logic                  ISA_FIFO_empty;
    logic [ISA+ADDR-1:0]   ISA_FIFO_dout;
    logic                  ISA_FIFO_rd_en;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_dir;
    logic [ADDR-1:0]       cmd_addr;
    logic [7:0]            cmd_len;
    logic                  DMA_FIFO1_empty;
    logic [BITLEN-1:0]     DMA_FIFO1_dout;
    logic                  DMA_FIFO1_rd_en;
    logic                  AEQ_FIFO_full;
    logic [BITLEN-1:0]     AEQ_FIFO_din;
    logic                  AEQ_FIFO_wr_en;
    logic                  EAQ1_FIFO_empty;
    logic [BITLEN-1:0]     EAQ1_FIFO_dout;
    logic                  EAQ1_FIFO_rd_en;
    logic                  EAQ2_FIFO_empty;
    logic [BITLEN-1:0]     EAQ2_FIFO_dout;
    logic                  EAQ2_FIFO_rd_en;
    logic                  DMA_FIFO2_full;
    logic [BITLEN-1:0]     DMA_FIFO2_din;
    logic                  DMA_FIFO2_wr_en;

    modport master (
        input  ISA_FIFO_empty, ISA_FIFO_dout, cmd_ready,
        input  DMA_FIFO1_empty, DMA_FIFO1_dout, AEQ_FIFO_full,
        input  EAQ1_FIFO_empty, EAQ1_FIFO_dout, EAQ2_FIFO_empty, EAQ2_FIFO_dout, DMA_FIFO2_full,
        output ISA_FIFO_rd_en, cmd_valid, cmd_dir, cmd_addr, cmd_len,
        output DMA_FIFO1_rd_en, AEQ_FIFO_din, AEQ_FIFO_wr_en,
        output EAQ1_FIFO_rd_en, EAQ2_FIFO_rd_en, DMA_FIFO2_din, DMA_FIFO2_wr_en
    );

    modport slave (
        output ISA_FIFO_empty, ISA_FIFO_dout, cmd_ready,
        output DMA_FIFO1_empty, DMA_FIFO1_dout, AEQ_FIFO_full,
        output EAQ1_FIFO_empty, EAQ1_FIFO_dout, EAQ2_FIFO_empty, EAQ2_FIFO_dout, DMA_FIFO2_full,
        input  ISA_FIFO_rd_en, cmd_valid, cmd_dir, cmd_addr, cmd_len,
        input  DMA_FIFO1_rd_en, AEQ_FIFO_din, AEQ_FIFO_wr_en,
        input  EAQ1_FIFO_rd_en, EAQ2_FIFO_rd_en, DMA_FIFO2_din, DMA_FIFO2_wr_en
    );
endinterface

// File: rtl/ap_dma_scheduler.sv
// Per-instruction AP datapath sequencer: pop instruction, issue DMA command, move a counted burst.
// Optional stall counter enabled by defining AP_STALL_CNT_EN.
module ap_dma_scheduler #(
    parameter int unsigned ISA      = 2,
    parameter int unsigned ADDR     = 32,
    parameter int unsigned BITLEN   = 64,
    parameter int unsigned RD_BEATS = 8,
    parameter int unsigned WR_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ap_dma_scheduler_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               bad_op,
    output logic [31:0]        stall_cnt
);

    localparam logic [ISA-1:0] OpRd  = ISA'(1);
    localparam logic [ISA-1:0] OpWr  = ISA'(2);
    localparam logic [7:0]     RdLen = 8'(RD_BEATS);
    localparam logic [7:0]     WrLen = 8'(WR_BEATS);

    typedef enum logic [2:0] {StIdle, StCmd, StRd, StWr, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            par_q, par_d;
    logic            dir_q, dir_d;
    logic [ADDR-1:0] addr_q, addr_d;
    logic            bad_op_q, bad_op_d;

    logic [ISA-1:0]  op_in;
    logic [7:0]      len;
    logic            last;
    logic            sel_empty;
    logic            rd_xfer;
    logic            wr_xfer;

    assign op_in     = bus.ISA_FIFO_dout[ISA+ADDR-1:ADDR];
    assign len       = dir_q ? WrLen : RdLen;
    assign last      = (cnt_q == len - 8'd1);
    assign sel_empty = par_q ? bus.EAQ2_FIFO_empty : bus.EAQ1_FIFO_empty;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            par_q    <= 1'b0;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            bad_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            dir_q    <= dir_d;
            addr_q   <= addr_d;
            bad_op_q <= bad_op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        dir_d    = dir_q;
        addr_d   = addr_q;
        bad_op_d = 1'b0;
        rd_xfer  = 1'b0;
        wr_xfer  = 1'b0;

        bus.ISA_FIFO_rd_en  = 1'b0;
        bus.cmd_valid       = 1'b0;
        bus.cmd_dir         = 1'b0;
        bus.cmd_addr        = '0;
        bus.cmd_len         = 8'd0;
        bus.DMA_FIFO1_rd_en = 1'b0;
        bus.AEQ_FIFO_wr_en  = 1'b0;
        bus.AEQ_FIFO_din    = {BITLEN{1'b0}};
        bus.EAQ1_FIFO_rd_en = 1'b0;
        bus.EAQ2_FIFO_rd_en = 1'b0;
        bus.DMA_FIFO2_wr_en = 1'b0;
        bus.DMA_FIFO2_din   = {BITLEN{1'b0}};

        unique case (state_q)
            StIdle: begin
                bus.ISA_FIFO_rd_en = ~bus.ISA_FIFO_empty;
                if (!bus.ISA_FIFO_empty) begin
                    if (op_in == OpRd || op_in == OpWr) begin
                        dir_d   = (op_in == OpWr);
                        addr_d  = bus.ISA_FIFO_dout[ADDR-1:0];
                        state_d = StCmd;
                    end else begin
                        bad_op_d = 1'b1;
                    end
                end
            end
            StCmd: begin
                bus.cmd_valid = 1'b1;
                bus.cmd_dir   = dir_q;
                bus.cmd_addr  = addr_q;
                bus.cmd_len   = len;
                if (bus.cmd_ready) begin
                    state_d = dir_q ? StWr : StRd;
                    cnt_d   = 8'd0;
                    par_d   = 1'b0;
                end
            end
            StRd: begin
                rd_xfer             = ~bus.DMA_FIFO1_empty & ~bus.AEQ_FIFO_full;
                bus.DMA_FIFO1_rd_en = rd_xfer;
                bus.AEQ_FIFO_wr_en  = rd_xfer;
                bus.AEQ_FIFO_din    = bus.DMA_FIFO1_dout;
                if (rd_xfer) begin
                    if (last) state_d = StDone;
                    else      cnt_d   = cnt_q + 8'd1;
                end
            end
            StWr: begin
                // Only the parity-selected queue may be popped; the other waits its turn.
                wr_xfer             = ~sel_empty & ~bus.DMA_FIFO2_full;
                bus.EAQ1_FIFO_rd_en = wr_xfer & ~par_q;
                bus.EAQ2_FIFO_rd_en = wr_xfer & par_q;
                bus.DMA_FIFO2_wr_en = wr_xfer;
                bus.DMA_FIFO2_din   = par_q ? bus.EAQ2_FIFO_dout : bus.EAQ1_FIFO_dout;
                if (wr_xfer) begin
                    par_d = ~par_q;
                    if (last) state_d = StDone;
                    else      cnt_d   = cnt_q + 8'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign bad_op = bad_op_q;

`ifdef AP_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        stalled;

    assign stalled = ((state_q == StRd) && !rd_xfer) || ((state_q == StWr) && !wr_xfer);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            stall_q <= 32'd0;
        end else if (stalled && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ap_dma_scheduler.sv
// Randomized bench for ap_dma_scheduler against a stream-level model of expected transfers.
// Stall-count expectation follows AP_STALL_CNT_EN when defined.
module tb_ap_dma_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy, done, bad_op;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    ap_dma_scheduler_if bus ();

    ap_dma_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .bad_op    (bad_op),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        logic        dir;
        logic [31:0] addr;
        logic [7:0]  len;
    } cmd_t;

    logic [33:0] isa_q[$];
    logic [63:0] dma1_q[$], eaq1_q[$], eaq2_q[$];
    logic [63:0] exp_aeq_q[$], exp_dma2_q[$];
    cmd_t        exp_cmd_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, done_cnt = 0, done_exp = 0, bad_cnt = 0, bad_exp = 0;
    int acc_cyc = 0, cur_len = 0, pop_cyc = 0, done_cyc = 0;
    int aeq_first = -1, aeq_last = -1, dma2_pushes = 0;
    logic [31:0] stall_exp = 0;
    bit rnd = 0;
    bit h_isa, h_d1, h_e1, h_e2, f_aeq, f_d2, rdy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_instr(input logic [1:0] op, input logic [31:0] addr);
        cmd_t c;
        logic [63:0] a, b;
        isa_q.push_back({op, addr});
        if (op == 2'b01) begin
            c.dir = 1'b0; c.addr = addr; c.len = 8'd8;
            exp_cmd_q.push_back(c);
            for (int i = 0; i < 8; i++) begin
                a = {$urandom, $urandom};
                dma1_q.push_back(a);
                exp_aeq_q.push_back(a);
            end
            done_exp++;
        end else if (op == 2'b10) begin
            c.dir = 1'b1; c.addr = addr; c.len = 8'd16;
            exp_cmd_q.push_back(c);
            for (int i = 0; i < 8; i++) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                eaq1_q.push_back(a);
                eaq2_q.push_back(b);
                exp_dma2_q.push_back(a);
                exp_dma2_q.push_back(b);
            end
            done_exp++;
        end else begin
            bad_exp++;
        end
    endtask

    task automatic drive();
        if (rnd) begin
            h_isa = ($urandom_range(0, 3) == 0);
            h_d1  = ($urandom_range(0, 3) == 0);
            h_e1  = ($urandom_range(0, 3) == 0);
            h_e2  = ($urandom_range(0, 3) == 0);
            f_aeq = ($urandom_range(0, 3) == 0);
            f_d2  = ($urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
        end else begin
            {h_isa, h_d1, h_e1, h_e2, f_aeq, f_d2} = '0;
            rdy = 1'b1;
        end
        bus.ISA_FIFO_empty  = (isa_q.size() == 0) || h_isa;
        bus.ISA_FIFO_dout   = (isa_q.size() > 0) ? isa_q[0] : '0;
        bus.cmd_ready       = rdy;
        bus.DMA_FIFO1_empty = (dma1_q.size() == 0) || h_d1;
        bus.DMA_FIFO1_dout  = (dma1_q.size() > 0) ? dma1_q[0] : '0;
        bus.AEQ_FIFO_full   = f_aeq;
        bus.EAQ1_FIFO_empty = (eaq1_q.size() == 0) || h_e1;
        bus.EAQ1_FIFO_dout  = (eaq1_q.size() > 0) ? eaq1_q[0] : '0;
        bus.EAQ2_FIFO_empty = (eaq2_q.size() == 0) || h_e2;
        bus.EAQ2_FIFO_dout  = (eaq2_q.size() > 0) ? eaq2_q[0] : '0;
        bus.DMA_FIFO2_full  = f_d2;
    endtask

    // Observes the cycle's settled outputs; every transfer seen here happens at the next edge.
    task automatic monitor();
        cyc++;
        check_eq("isa_legal", bus.ISA_FIFO_rd_en & bus.ISA_FIFO_empty, 0);
        check_eq("d1_legal", bus.DMA_FIFO1_rd_en & (bus.DMA_FIFO1_empty | bus.AEQ_FIFO_full), 0);
        check_eq("aeq_pair", bus.AEQ_FIFO_wr_en, bus.DMA_FIFO1_rd_en);
        check_eq("eaq_excl", bus.EAQ1_FIFO_rd_en & bus.EAQ2_FIFO_rd_en, 0);
        check_eq("dma2_pair", bus.DMA_FIFO2_wr_en, bus.EAQ1_FIFO_rd_en | bus.EAQ2_FIFO_rd_en);
        check_eq("eaq1_legal", bus.EAQ1_FIFO_rd_en & (bus.EAQ1_FIFO_empty | bus.DMA_FIFO2_full), 0);
        check_eq("eaq2_legal", bus.EAQ2_FIFO_rd_en & (bus.EAQ2_FIFO_empty | bus.DMA_FIFO2_full), 0);

        if (bus.ISA_FIFO_rd_en && isa_q.size() > 0) begin
            void'(isa_q.pop_front());
            pop_cyc = cyc;
        end
        if (bus.cmd_valid) begin
            if (exp_cmd_q.size() == 0) begin
                check_eq("cmd_spurious", bus.cmd_valid, 0);
            end else begin
                check_eq("cmd_addr", bus.cmd_addr, exp_cmd_q[0].addr);
                check_eq("cmd_dir", bus.cmd_dir, exp_cmd_q[0].dir);
                check_eq("cmd_len", bus.cmd_len, exp_cmd_q[0].len);
                if (bus.cmd_ready) begin
                    cur_len = int'(exp_cmd_q[0].len);
                    acc_cyc = cyc;
                    void'(exp_cmd_q.pop_front());
                end
            end
        end
        if (bus.AEQ_FIFO_wr_en) begin
            if (exp_aeq_q.size() == 0) check_eq("aeq_spurious", bus.AEQ_FIFO_wr_en, 0);
            else check_eq("aeq_data", bus.AEQ_FIFO_din, exp_aeq_q.pop_front());
            if (dma1_q.size() > 0) void'(dma1_q.pop_front());
            if (aeq_first < 0) aeq_first = cyc;
            aeq_last = cyc;
        end
        if (bus.DMA_FIFO2_wr_en) begin
            if (exp_dma2_q.size() == 0) check_eq("dma2_spurious", bus.DMA_FIFO2_wr_en, 0);
            else check_eq("dma2_data", bus.DMA_FIFO2_din, exp_dma2_q.pop_front());
            if (bus.EAQ1_FIFO_rd_en && eaq1_q.size() > 0) void'(eaq1_q.pop_front());
            if (bus.EAQ2_FIFO_rd_en && eaq2_q.size() > 0) void'(eaq2_q.pop_front());
            dma2_pushes++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            // Cycles spent in the burst beyond one per beat are stalls.
            stall_exp = stall_exp + 32'(cyc - acc_cyc - 1 - cur_len);
        end
        if (bad_op) bad_cnt++;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        while ((isa_q.size() > 0 || exp_cmd_q.size() > 0 || exp_aeq_q.size() > 0 ||
                exp_dma2_q.size() > 0 || busy) && n < budget) begin
            cycle();
            n++;
        end
        repeat (3) cycle();
        check_eq({tag, "_drain"}, 64'(isa_q.size() + exp_cmd_q.size() + exp_aeq_q.size() +
                 exp_dma2_q.size()), 0);
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_totals(input string tag);
        check_eq({tag, "_done_cnt"}, done_cnt, done_exp);
        check_eq({tag, "_bad_cnt"}, bad_cnt, bad_exp);
`ifdef AP_STALL_CNT_EN
        check_eq({tag, "_stall"}, stall_cnt, stall_exp);
`else
        check_eq({tag, "_stall"}, stall_cnt, 0);
`endif
    endtask

    initial begin
        int n, base;
        logic [1:0] ops [6];
        rst_n = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_bad_op", bad_op, 0);
        check_eq("rst_cmd_valid", bus.cmd_valid, 0);
        check_eq("rst_stall", stall_cnt, 0);
        rst_n = 1'b0;

        // Directed read, no stalls: 11-cycle turnaround, 8 back-to-back beats.
        push_instr(2'b01, 32'h1000);
        drive();
        run_until_idle("rd", 200);
        check_eq("rd_latency", done_cyc - pop_cyc, 10);
        check_eq("rd_beat_span", aeq_last - aeq_first, 7);
        check_totals("rd");

        // Directed write, no stalls: interleaved 16 beats.
        push_instr(2'b10, 32'h2000);
        drive();
        run_until_idle("wr", 200);
        check_eq("wr_latency", done_cyc - pop_cyc, 18);
        check_totals("wr");

        // Bad opcode followed by a valid read.
        push_instr(2'b11, 32'h3000);
        push_instr(2'b01, 32'h3100);
        drive();
        run_until_idle("bad", 200);
        check_totals("bad");

        // Reset in the middle of a write burst.
        base = dma2_pushes;
        push_instr(2'b10, 32'h4000);
        drive();
        n = 0;
        while (dma2_pushes - base < 5 && n < 200) begin
            cycle();
            n++;
        end
        check_eq("rst_reach_beat5", dma2_pushes - base, 5);
        rst_n = 1'b1;
        cycle();
        rst_n = 1'b0;
        isa_q.delete(); dma1_q.delete(); eaq1_q.delete(); eaq2_q.delete();
        exp_aeq_q.delete(); exp_dma2_q.delete(); exp_cmd_q.delete();
        done_cnt = 0; done_exp = 0; bad_cnt = 0; bad_exp = 0; stall_exp = 0;
        drive();
        @(negedge clk);
        check_eq("post_rst_outputs", {busy, done, bad_op, bus.cmd_valid, bus.ISA_FIFO_rd_en,
                 bus.DMA_FIFO1_rd_en, bus.AEQ_FIFO_wr_en, bus.EAQ1_FIFO_rd_en,
                 bus.EAQ2_FIFO_rd_en, bus.DMA_FIFO2_wr_en}, 0);
        check_eq("post_rst_stall", stall_cnt, 0);
        @(posedge clk);
        #1;
        push_instr(2'b01, 32'h5000);
        drive();
        run_until_idle("post_rst", 200);
        check_totals("post_rst");

        // Randomized mix with backpressure, starvation and bad opcodes.
        ops = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11};
        rnd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            push_instr(ops[$urandom_range(0, 5)], $urandom);
        end
        drive();
        run_until_idle("rand", 20000);
        check_totals("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ap_dma_scheduler.md
Name: ap_dma_scheduler

Overview:
- Sequences the AP datapath, one instruction at a time.
- Pops a {opcode, address} instruction, issues a DMA burst command, then moves exactly the burst's beats.
- Read path: DMA_FIFO1 into AEQ. Write path: EAQ1/EAQ2 interleaved into DMA_FIFO2.
- Sits between the instruction FIFO, the DMA engine and the accelerator queues, replacing free-running FIFO draining with counted, per-instruction transfers.

Parameters:
- ISA, 2, opcode width
- ADDR, 32, address width
- BITLEN, 64, data beat width
- RD_BEATS, 8, beats per read instruction (opcode 2'b01)
- WR_BEATS, 16, beats per write instruction (opcode 2'b10)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-high
- ISA_FIFO_empty  in  1  instruction FIFO empty
- ISA_FIFO_dout  in  ISA+ADDR  [ISA+ADDR-1:ADDR] opcode, [ADDR-1:0] address
- ISA_FIFO_rd_en  out  1  instruction pop
- cmd_valid  out  1  DMA command valid
- cmd_ready  in  1  DMA engine accepts command
- cmd_dir  out  1  0 = read, 1 = write
- cmd_addr  out  ADDR  burst start address
- cmd_len  out  8  burst beats
- DMA_FIFO1_empty  in  1  DMA read-data FIFO empty
- DMA_FIFO1_dout  in  BITLEN  DMA read-data FIFO data
- DMA_FIFO1_rd_en  out  1  DMA read-data FIFO pop
- AEQ_FIFO_full  in  1  AEQ FIFO full
- AEQ_FIFO_din  out  BITLEN  AEQ FIFO data
- AEQ_FIFO_wr_en  out  1  AEQ FIFO push
- EAQ1_FIFO_empty  in  1  EAQ1 FIFO empty
- EAQ1_FIFO_dout  in  BITLEN  EAQ1 FIFO data
- EAQ1_FIFO_rd_en  out  1  EAQ1 FIFO pop
- EAQ2_FIFO_empty  in  1  EAQ2 FIFO empty
- EAQ2_FIFO_dout  in  BITLEN  EAQ2 FIFO data
- EAQ2_FIFO_rd_en  out  1  EAQ2 FIFO pop
- DMA_FIFO2_full  in  1  DMA write-data FIFO full
- DMA_FIFO2_din  out  BITLEN  DMA write-data FIFO data
- DMA_FIFO2_wr_en  out  1  DMA write-data FIFO push
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse per completed instruction
- bad_op  out  1  one-cycle pulse per discarded opcode
- stall_cnt  out  32  stall cycles (optional feature)

Behaviour:
- All FIFOs are first-word-fall-through: dout is valid whenever empty=0. Data moves in a cycle where rd_en=1.
- Reset: state=IDLE; beat counter, parity bit, latched op/addr, and stall_cnt cleared. All outputs 0.
- Reset mid-burst aborts immediately. No flushing; partially moved data stays in the FIFOs.
- FSM states:
  - IDLE: ISA_FIFO_rd_en = ~ISA_FIFO_empty (combinational). On pop, latch opcode/address.
    - Opcode 01 -> CMD, len=RD_BEATS, dir=0.
    - Opcode 10 -> CMD, len=WR_BEATS, dir=1.
    - Opcode 00/11 -> stay IDLE, pulse bad_op next cycle.
  - CMD: cmd_valid=1. cmd_addr/dir/len held stable until cmd_ready. On cmd_valid&cmd_ready -> RD or WR; beat counter=0.
  - RD:
    - DMA_FIFO1_rd_en = AEQ_FIFO_wr_en = ~DMA_FIFO1_empty & ~AEQ_FIFO_full.
    - AEQ_FIFO_din = DMA_FIFO1_dout (zero-latency pass-through).
    - Counter increments per beat. Last beat (counter==len-1) -> DONE.
  - WR:
    - Parity bit selects the source: 0 = EAQ1, 1 = EAQ2. Parity is 0 at burst start and toggles only on a completed beat.
    - Selected rd_en = DMA_FIFO2_wr_en = ~selected_empty & ~DMA_FIFO2_full. The unselected rd_en stays 0, even if that queue holds data.
    - DMA_FIFO2_din = selected dout.
    - Last beat -> DONE.
  - DONE: done=1 for one cycle -> IDLE. No instruction pop in DONE.
- Minimum instruction turnaround, with no stalls: 1 (IDLE) + 1 (CMD) + len + 1 (DONE) cycles.
- cmd_len carries len zero-extended to 8 bits. RD_BEATS and WR_BEATS must be in 1..255.
- Beat counter is 8 bits and never wraps past len-1.
- Simultaneous ~empty and full: no transfer, no counter change.
- Outside RD/WR, every data rd_en/wr_en is 0.

Optional Feature:
- Macro: AP_STALL_CNT_EN.
- Defined: stall_cnt increments in RD/WR every cycle with no beat transfer. It saturates at 32'hFFFFFFFF, clears on reset, and is never cleared by instructions.
- Undefined: stall_cnt tied to 0 and no counter flops exist.

Test Plan:
- Read: ISA_FIFO_dout={2'b01,32'h1000}, cmd_ready=1, DMA_FIFO1 preloaded with 8 beats 0..7, AEQ never full -> cmd_addr=32'h1000, cmd_len=8, cmd_dir=0. AEQ receives 0..7 in order on 8 consecutive cycles; one done pulse; 11 cycles from pop to done.
- Write interleave: opcode 10, EAQ1 holds A0..A7, EAQ2 holds B0..B7 -> DMA_FIFO2 receives A0,B0,A1,B1,...,A7,B7 (16 beats), then done.
- Backpressure: read burst with AEQ_FIFO_full held 1 for cycles 3-6 of the burst -> no AEQ push and no DMA_FIFO1 pop in those cycles; all 8 beats still delivered in order. With AP_STALL_CNT_EN, stall_cnt=4.
- Starved source: write burst with EAQ2 empty after B2 -> block waits on EAQ2, no EAQ1 pop; resumes with B3 when EAQ2 refills.
- Bad opcode: opcode 2'b11 -> one bad_op pulse, cmd_valid stays 0. The next valid instruction is processed normally.
- Reset mid-burst: rst_n=1 at beat 5 of a write -> next cycle busy=0, all enables 0. A new read instruction after reset completes normally with 8 beats.
